// File: rtl/mem_pkg.sv
// Shared opcodes, funct3 encodings and FSM states for the memory-stage data port.
package mem_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // funct3[1:0] encodes access size: 00 byte, 01 halfword, 10 word.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
    logic r;
    r = 1'b0;
    if (f3[1:0] == 2'b01) r = addr_lo[0];
    else if (f3[1:0] == 2'b10) r = (addr_lo != 2'b00);
    return r;
  endfunction

endpackage

// File: rtl/dmem_port_load_align.sv
// Load lane extraction and sign/zero extension; purely combinational so the
// writeback mux can reuse it.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_load_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = 8'h00;
    case (i_addr_lo)
      2'd0: w_byte = i_rdata[7:0];
      2'd1: w_byte = i_rdata[15:8];
      2'd2: w_byte = i_rdata[23:16];
      2'd3: w_byte = i_rdata[31:24];
      default: w_byte = 8'h00;
    endcase
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

    o_load_data = i_rdata;
    case (i_funct3)
      F3_B:    o_load_data = {{24{w_byte[7]}}, w_byte};
      F3_H:    o_load_data = {{16{w_half[15]}}, w_half};
      F3_BU:   o_load_data = {24'h000000, w_byte};
      F3_HU:   o_load_data = {16'h0000, w_half};
      default: o_load_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/dmem_port.sv
// Memory-stage data port: decodes load/store, runs req/gnt/rvalid on the data bus,
// and stalls the pipeline until the access (or a misalignment exception) completes.
module dmem_port
  import mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] alu_out_acc,
  input  logic [31:0] data_b_acc,
  input  logic [31:0] instr_acc,
  input  logic        MemRW,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [31:0] load_data,
  output logic        misalign_exc,
  output logic        stall
);

  state_t      r_state;
  logic        r_mem_req;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [3:0]  r_mem_be;
  logic [31:0] r_mem_wdata;
  logic [2:0]  r_funct3;
  logic [1:0]  r_addr_lo;
  logic [31:0] r_load_data;
  logic        r_misalign;

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic        w_is_store;
  logic        w_is_load;
  logic        w_access;
  logic        w_misalign;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_fmt_data;
  logic        w_unused_instr;

  assign w_opcode = instr_acc[6:0];
  assign w_funct3 = instr_acc[14:12];
  assign w_unused_instr = ^{instr_acc[31:15], instr_acc[11:7]};

  always_comb begin
    w_is_store = MemRW && (w_opcode == OP_STORE) &&
                 (w_funct3 == F3_B || w_funct3 == F3_H || w_funct3 == F3_W);
    w_is_load  = (w_opcode == OP_LOAD) &&
                 (w_funct3 == F3_B || w_funct3 == F3_H || w_funct3 == F3_W ||
                  w_funct3 == F3_BU || w_funct3 == F3_HU);
    w_access   = w_is_store || w_is_load;
    w_misalign = is_misaligned(w_funct3, alu_out_acc[1:0]);
  end

  // Lane generation keys off size only, so loads get a matching enable mask too.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = data_b_acc;
    case (w_funct3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << alu_out_acc[1:0];
        w_wdata = {4{data_b_acc[7:0]}};
      end
      2'b01: begin
        w_be    = alu_out_acc[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{data_b_acc[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = data_b_acc;
      end
    endcase
  end

  load_align u_load_align (
    .i_rdata     (mem_rdata),
    .i_addr_lo   (r_addr_lo),
    .i_funct3    (r_funct3),
    .o_load_data (w_fmt_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 32'h0;
      r_mem_be    <= 4'h0;
      r_mem_wdata <= 32'h0;
      r_funct3    <= 3'b000;
      r_addr_lo   <= 2'b00;
      r_load_data <= 32'h0;
      r_misalign  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_access && w_misalign) begin
            r_misalign <= 1'b1;
            r_state    <= S_DONE;
          end else if (w_access) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= w_is_store;
            r_mem_addr  <= {alu_out_acc[31:2], 2'b00};
            r_mem_be    <= w_be;
            r_mem_wdata <= w_wdata;
            r_funct3    <= w_funct3;
            r_addr_lo   <= alu_out_acc[1:0];
            r_state     <= S_REQ;
          end
        end
        S_REQ: begin
          if (mem_gnt) begin
            r_mem_req <= 1'b0;
            r_state   <= r_mem_we ? S_DONE : S_RESP;
          end
        end
        S_RESP: begin
          if (mem_rvalid) begin
            r_load_data <= w_fmt_data;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          r_misalign <= 1'b0;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    stall = 1'b0;
    if (!rst) begin
      case (r_state)
        S_IDLE:  stall = w_access;
        S_REQ:   stall = 1'b1;
        S_RESP:  stall = 1'b1;
        default: stall = 1'b0;
      endcase
    end
  end

  assign mem_req      = r_mem_req;
  assign mem_we       = r_mem_we;
  assign mem_addr     = r_mem_addr;
  assign mem_be       = r_mem_be;
  assign mem_wdata    = r_mem_wdata;
  assign load_data    = r_load_data;
  assign misalign_exc = r_misalign;

endmodule

// File: tb/tb_dmem_port.sv
// Bench for dmem_port: directed scenarios then randomized accesses against a
// behavioural model of lane selection, extension and handshake timing.
module tb_dmem_port;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alu_out_acc;
  logic [31:0] data_b_acc;
  logic [31:0] instr_acc;
  logic        MemRW;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [31:0] load_data;
  logic        misalign_exc;
  logic        stall;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_ld;

  localparam logic [31:0] NOP = 32'h00000013;

  always #5 clk = ~clk;

  dmem_port dut (
    .clk          (clk),
    .rst          (rst),
    .alu_out_acc  (alu_out_acc),
    .data_b_acc   (data_b_acc),
    .instr_acc    (instr_acc),
    .MemRW        (MemRW),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_be       (mem_be),
    .mem_wdata    (mem_wdata),
    .mem_gnt      (mem_gnt),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata),
    .load_data    (load_data),
    .misalign_exc (misalign_exc),
    .stall        (stall)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int size_bytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] a);
    int n;
    int m;
    n = size_bytes(f3);
    m = ((1 << n) - 1) << (a % 4);
    return m[3:0];
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] r;
    if (size_bytes(f3) == 1) r = (d & 32'hFF) * 32'h01010101;
    else if (size_bytes(f3) == 2) r = (d & 32'hFFFF) * 32'h00010001;
    else r = d;
    return r;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
    logic [31:0] sh;
    logic [31:0] r;
    sh = w >> (8 * (a % 4));
    case (f3)
      3'd0: begin r = sh & 32'hFF;   if (r >= 32'd128)   r = r - 32'd256;   end
      3'd1: begin r = sh & 32'hFFFF; if (r >= 32'd32768) r = r - 32'd65536; end
      3'd4: r = sh & 32'hFF;
      3'd5: r = sh & 32'hFFFF;
      default: r = w;
    endcase
    return r;
  endfunction

  // Drives one instruction through the access stage and checks every cycle until
  // it retires; inputs change just after posedge, outputs are sampled at negedge.
  task automatic run_access(input logic [31:0] ins, input logic rw, input logic [31:0] a,
                            input logic [31:0] d, input int gnt_dly, input int rv_dly,
                            input logic [31:0] rdat);
    logic [6:0] opc;
    logic [2:0] f3;
    logic       is_st;
    logic       is_ld;
    logic       mis;
    opc   = ins[6:0];
    f3    = ins[14:12];
    is_st = rw && opc == 7'b0100011 && f3 <= 3'd2;
    is_ld = opc == 7'b0000011 && (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    mis   = (is_st || is_ld) && (a % size_bytes(f3)) != 0;
    instr_acc = ins; MemRW = rw; alu_out_acc = a; data_b_acc = d;
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    @(negedge clk);
    if (!is_st && !is_ld) begin
      chk1("noacc_stall", stall, 1'b0);
      chk1("noacc_req", mem_req, 1'b0);
      step();
      @(negedge clk);
      chk1("noacc_stall2", stall, 1'b0);
      chk("noacc_ld", load_data, exp_ld);
      step();
      return;
    end
    chk1("detect_stall", stall, 1'b1);
    chk1("detect_req", mem_req, 1'b0);
    step();
    if (mis) begin
      @(negedge clk);
      chk1("mis_exc", misalign_exc, 1'b1);
      chk1("mis_stall", stall, 1'b0);
      chk1("mis_req", mem_req, 1'b0);
      chk("mis_ld", load_data, exp_ld);
      step();
      instr_acc = NOP; MemRW = 1'b0;
      @(negedge clk);
      chk1("mis_exc_clr", misalign_exc, 1'b0);
      step();
      return;
    end
    for (int k = 0; k <= gnt_dly; k++) begin
      mem_gnt    = (k == gnt_dly);
      mem_rvalid = 1'($urandom_range(0, 1));
      mem_rdata  = $urandom;
      @(negedge clk);
      chk1("req_req", mem_req, 1'b1);
      chk1("req_we", mem_we, is_st);
      chk("req_addr", mem_addr, {a[31:2], 2'b00});
      chk1("req_stall", stall, 1'b1);
      if (is_st) begin
        chk("req_be", {28'h0, mem_be}, {28'h0, ref_be(f3, a)});
        chk("req_wdata", mem_wdata, ref_wdata(f3, d));
      end
      step();
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    if (is_ld) begin
      for (int k = 0; k <= rv_dly; k++) begin
        mem_rvalid = (k == rv_dly);
        mem_rdata  = (k == rv_dly) ? rdat : $urandom;
        mem_gnt    = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk1("resp_stall", stall, 1'b1);
        chk1("resp_req", mem_req, 1'b0);
        step();
      end
      exp_ld = ref_load(f3, a, rdat);
    end
    mem_gnt = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = $urandom;
    @(negedge clk);
    chk1("done_stall", stall, 1'b0);
    chk1("done_req", mem_req, 1'b0);
    chk1("done_exc", misalign_exc, 1'b0);
    chk("done_ld", load_data, exp_ld);
    step();
    instr_acc = NOP; MemRW = 1'b0;
    @(negedge clk);
    chk("idle_ld_hold", load_data, exp_ld);
    step();
    mem_rvalid = 1'b0;
  endtask

  function automatic logic [31:0] mk_ins(input logic [6:0] opc, input logic [2:0] f3);
    logic [31:0] r;
    r = $urandom;
    r[6:0] = opc;
    r[14:12] = f3;
    return r;
  endfunction

  initial begin
    rst = 1'b1; exp_ld = 32'h0;
    instr_acc = mk_ins(7'b0100011, 3'd2); MemRW = 1'b1;
    alu_out_acc = 32'h100; data_b_acc = 32'h1234_5678;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    step();
    step();
    @(negedge clk);
    chk1("rst_stall", stall, 1'b0);
    chk1("rst_req", mem_req, 1'b0);
    chk1("rst_we", mem_we, 1'b0);
    chk("rst_be", {28'h0, mem_be}, 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_ld", load_data, 32'h0);
    chk1("rst_exc", misalign_exc, 1'b0);
    step();
    rst = 1'b0; instr_acc = NOP; MemRW = 1'b0;
    step();

    run_access(mk_ins(7'b0100011, 3'd2), 1'b1, 32'h100, 32'hDEADBEEF, 0, 0, 32'h0);
    run_access(mk_ins(7'b0100011, 3'd0), 1'b1, 32'h103, 32'h000000A5, 0, 0, 32'h0);
    run_access(mk_ins(7'b0000011, 3'd0), 1'b0, 32'h102, 32'h0, 0, 0, 32'h00800000);
    chk("lb_val", load_data, 32'hFFFFFF80);
    run_access(mk_ins(7'b0000011, 3'd4), 1'b0, 32'h102, 32'h0, 0, 0, 32'h00800000);
    chk("lbu_val", load_data, 32'h00000080);
    run_access(mk_ins(7'b0000011, 3'd5), 1'b0, 32'h102, 32'h0, 1, 2, 32'h80010000);
    chk("lhu_val", load_data, 32'h00008001);
    run_access(mk_ins(7'b0000011, 3'd2), 1'b0, 32'h101, 32'h0, 0, 0, 32'h0);
    run_access(mk_ins(7'b0100011, 3'd1), 1'b1, 32'h200, 32'hCAFE_1234, 3, 0, 32'h0);
    run_access(mk_ins(7'b0100011, 3'd2), 1'b0, 32'h300, 32'h1, 0, 0, 32'h0);

    // Reset while a load waits for its response.
    instr_acc = mk_ins(7'b0000011, 3'd2); MemRW = 1'b0; alu_out_acc = 32'h400;
    step();
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    @(negedge clk);
    chk1("rresp_stall", stall, 1'b1);
    step();
    rst = 1'b1; instr_acc = NOP;
    @(negedge clk);
    chk1("rresp_stall_rst", stall, 1'b0);
    step();
    rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
    exp_ld = 32'h0;
    @(negedge clk);
    chk1("rresp_req", mem_req, 1'b0);
    chk1("rresp_stall_idle", stall, 1'b0);
    step();
    mem_rvalid = 1'b0;
    @(negedge clk);
    chk("rresp_ld", load_data, 32'h0);
    step();

    for (int i = 0; i < 300; i++) begin
      int          kind;
      logic [2:0]  f3;
      logic [31:0] a;
      kind = $urandom_range(0, 4);
      a = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(0, 3));
      if (kind == 0) begin
        f3 = 3'($urandom_range(0, 2));
        run_access(mk_ins(7'b0100011, f3), 1'b1, a, $urandom,
                   $urandom_range(0, 3), 0, 32'h0);
      end else if (kind <= 2) begin
        case ($urandom_range(0, 4))
          0: f3 = 3'd0;
          1: f3 = 3'd1;
          2: f3 = 3'd2;
          3: f3 = 3'd4;
          default: f3 = 3'd5;
        endcase
        run_access(mk_ins(7'b0000011, f3), 1'($urandom_range(0, 1)), a, $urandom,
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
      end else if (kind == 3) begin
        run_access(mk_ins(7'b0100011, 3'($urandom_range(3, 7))), 1'b1, a, $urandom, 0, 0, 32'h0);
      end else begin
        run_access(mk_ins(7'b0110011, 3'($urandom_range(0, 7))), 1'($urandom_range(0, 1)),
                   a, $urandom, 0, 0, 32'h0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
